// File: rtl/shift_add_mult.sv
// Sequential shift-add multiplier: two p_WORD_WIDTH/2-bit operands in,
// one p_WORD_WIDTH-bit product out, with one add/shift step per clock.
// Valid/ready handshake on both the operand side and the product side.
//
// Optional build macro: SHIFT_ADD_MULT_SIGNED_EN
//   defined   -> operands are two's complement; magnitudes are multiplied
//                and the product is negated on the way into DONE
//   undefined -> plain unsigned multiply, no sign logic
//
// state | meaning
// IDLE  | ready for an operand pair
// RUN   | N add/shift steps in progress
// DONE  | product held until downstream takes it
module shift_add_mult #(
    parameter int p_WORD_WIDTH = 8
) (
    input  logic                      i_CLK,
    input  logic                      i_RST_N,
    input  logic                      i_VALID,
    output logic                      o_READY,
    input  logic [p_WORD_WIDTH/2-1:0] i_A,
    input  logic [p_WORD_WIDTH/2-1:0] i_B,
    output logic                      o_VALID,
    input  logic                      i_READY,
    output logic [p_WORD_WIDTH-1:0]   o_PRODUCT
);

    localparam int N  = p_WORD_WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (((p_WORD_WIDTH % 2) != 0) || (p_WORD_WIDTH < 4)) begin : g_bad_width
            $error("shift_add_mult: p_WORD_WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [N-1:0]   mcand;
    logic [2*N:0]   acc;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] product;

    logic [N-1:0]   a_load;
    logic [N-1:0]   b_load;
    logic [N:0]     upper_sum;
    logic [2*N:0]   acc_step;
    logic [2*N-1:0] result;
    logic           last_step;

`ifdef SHIFT_ADD_MULT_SIGNED_EN
    logic           neg;

    // Magnitudes in N bits; -2^(N-1) maps onto unsigned 2^(N-1), which is exact.
    assign a_load = i_A[N-1] ? (-i_A) : i_A;
    assign b_load = i_B[N-1] ? (-i_B) : i_B;
    assign result = neg ? (-acc_step[2*N-1:0]) : acc_step[2*N-1:0];

    // Result sign captured alongside the operands
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            neg <= 1'b0;
        end else if ((state == IDLE) && i_VALID) begin
            neg <= i_A[N-1] ^ i_B[N-1];
        end
    end
`else
    assign a_load = i_A;
    assign b_load = i_B;
    assign result = acc_step[2*N-1:0];
`endif

    // One step: conditional add into the upper half (acc[2N] is always zero
    // here, so it simply becomes the carry), then a logical right shift.
    assign upper_sum = acc[2*N:N] + (acc[0] ? {1'b0, mcand} : '0);
    assign acc_step  = {upper_sum, acc[N-1:0]} >> 1;
    assign last_step = (cnt == CW'(N - 1));
    assign o_PRODUCT = product;

    // State register
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        o_READY   = 1'b0;
        o_VALID   = 1'b0;
        case (state)
            IDLE: begin
                o_READY = 1'b1;
                if (i_VALID) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                o_VALID = 1'b1;
                if (i_READY) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, add/shift datapath and product register
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            mcand   <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_VALID) begin
                        mcand <= a_load;
                        acc   <= {{(N + 1){1'b0}}, b_load};
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                    if (last_step) begin
                        product <= result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult.sv
// Bench for shift_add_mult: fixed vectors, backpressure and mid-RUN reset
// on an 8-bit instance, randomized operands with stalls on a 16-bit instance.
module tb_shift_add_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;

    logic       va8, rd8, ov8, ir8;
    logic [3:0] a8, b8;
    logic [7:0] p8;

    logic        va16, rd16, ov16, ir16;
    logic [7:0]  a16, b16;
    logic [15:0] p16;

    shift_add_mult #(.p_WORD_WIDTH(8)) u_dut8 (
        .i_CLK     (clk),
        .i_RST_N   (rst_n),
        .i_VALID   (va8),
        .o_READY   (rd8),
        .i_A       (a8),
        .i_B       (b8),
        .o_VALID   (ov8),
        .i_READY   (ir8),
        .o_PRODUCT (p8)
    );

    shift_add_mult #(.p_WORD_WIDTH(16)) u_dut16 (
        .i_CLK     (clk),
        .i_RST_N   (rst_n),
        .i_VALID   (va16),
        .o_READY   (rd16),
        .i_A       (a16),
        .i_B       (b16),
        .o_VALID   (ov16),
        .i_READY   (ir16),
        .o_PRODUCT (p16)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp_u;
        logic [7:0] exp_s;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [7:0] pick(input logic [7:0] u, input logic [7:0] s);
`ifdef SHIFT_ADD_MULT_SIGNED_EN
        return s;
`else
        return u;
`endif
    endfunction

    // Reference product for n-bit operands, from plain integer arithmetic
    function automatic logic [31:0] ref_mult(input int unsigned a, input int unsigned b, input int n);
        longint sa, sb, p;
        sa = longint'(a);
        sb = longint'(b);
`ifdef SHIFT_ADD_MULT_SIGNED_EN
        if (a >= (32'd1 << (n - 1))) sa = sa - (longint'(1) << n);
        if (b >= (32'd1 << (n - 1))) sb = sb - (longint'(1) << n);
`endif
        p = sa * sb;
        return 32'(p & ((longint'(1) << (2 * n)) - 1));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One full transaction: accept, wait for DONE (bounded), optional stall,
    // handoff. poke drives a new operand pair during the stall; noise toggles
    // i_READY while the multiply is still running.
    task automatic run_op(input bit wide, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input int stall, input bit poke, input bit noise);
        int lat;
        @(negedge clk);
        check("ready_idle", wide ? rd16 : rd8, 1);
        if (wide) begin
            a16 = a; b16 = b; va16 = 1'b1;
        end else begin
            a8 = a[3:0]; b8 = b[3:0]; va8 = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        va8 = 1'b0; va16 = 1'b0;
        a8 = ~a8; b8 = ~b8; a16 = ~a16; b16 = ~b16;
        lat = 0;
        while (((wide ? ov16 : ov8) !== 1'b1) && (lat < 40)) begin
            if (noise) begin
                ir16 = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        ir8 = 1'b0; ir16 = 1'b0;
        check("latency", lat, wide ? 8 : 4);
        check("product", wide ? p16 : {8'h00, p8}, exp);
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                va8 = 1'b1; va16 = 1'b1;
                a8 = 4'($urandom); b8 = 4'($urandom);
                a16 = 8'($urandom); b16 = 8'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            check("stall_valid", wide ? ov16 : ov8, 1);
            check("stall_product", wide ? p16 : {8'h00, p8}, exp);
            check("stall_ready", wide ? rd16 : rd8, 0);
        end
        va8 = 1'b0; va16 = 1'b0;
        if (wide) ir16 = 1'b1; else ir8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ir8 = 1'b0; ir16 = 1'b0;
        check("ready_after", wide ? rd16 : rd8, 1);
        check("valid_after", wide ? ov16 : ov8, 0);
        check("product_hold", wide ? p16 : {8'h00, p8}, exp);
    endtask

    initial begin
        logic [7:0]  ra, rb;
        logic [15:0] rexp;

        vecs[0] = '{4'hD, 4'hB, 8'h8F, 8'h0F};
        vecs[1] = '{4'hF, 4'hF, 8'hE1, 8'h01};
        vecs[2] = '{4'h0, 4'h7, 8'h00, 8'h00};
        vecs[3] = '{4'h9, 4'h0, 8'h00, 8'h00};
        vecs[4] = '{4'hD, 4'h5, 8'h41, 8'hF1};
        vecs[5] = '{4'h8, 4'h8, 8'h40, 8'h40};
        vecs[6] = '{4'h8, 4'h7, 8'h38, 8'hC8};
        vecs[7] = '{4'h3, 4'h5, 8'h0F, 8'h0F};
        vecs[8] = '{4'h1, 4'hF, 8'h0F, 8'hFF};
        vecs[9] = '{4'h7, 4'h7, 8'h31, 8'h31};

        rst_n = 1'b0;
        va8 = 0; ir8 = 0; a8 = 0; b8 = 0;
        va16 = 0; ir16 = 0; a16 = 0; b16 = 0;
        #2;
        check("reset_valid", ov8, 0);
        check("reset_product", p8, 0);
        check("reset_product16", p16, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_ready", rd8, 1);
        check("release_valid16", ov16, 0);

        for (int i = 0; i < 10; i++) begin
            run_op(1'b0, {4'h0, vecs[i].a}, {4'h0, vecs[i].b},
                   {8'h00, pick(vecs[i].exp_u, vecs[i].exp_s)}, (i == 0) ? 2 : 0, 1'b0, 1'b0);
        end

        // Backpressure with new operands offered throughout DONE
        run_op(1'b0, 8'h0D, 8'h0B, {8'h00, pick(8'h8F, 8'h0F)}, 5, 1'b1, 1'b0);

        // Asynchronous reset between edges after two RUN steps
        @(negedge clk);
        a8 = 4'hF; b8 = 4'hF; va8 = 1'b1;
        @(posedge clk);
        #1 va8 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_valid", ov8, 0);
        check("midrun_reset_product", p8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrun_release_ready", rd8, 1);
        run_op(1'b0, 8'h03, 8'h05, 16'h000F, 0, 1'b0, 1'b0);

        // Randomized 16-bit traffic with downstream stalls
        for (int i = 0; i < 1000; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rexp = 16'(ref_mult(ra, rb, 8));
            run_op(1'b1, ra, rb, rexp, int'($urandom_range(0, 3)), 1'b0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
